// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared types and encodings for the multi-cycle MIPS control path:
// FSM state encoding, instruction classes, opcode/funct constants, ALU
// operation and PC-source encodings. No ports (package).
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_J       = 3'd5,
        CLS_ILLEGAL = 3'd6
    } ins_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // Wide enough for the largest legal memory timeout (255).
    localparam int TMO_W = 8;

endpackage

// File: rtl/ins_class_decode.sv
// ---------------------------------------------------------------------------
// ins_class_decode
// Purely combinational instruction classifier, shared with the single-cycle
// decoder. Maps an instruction word to its class and the ALU operation it
// needs in the execute step.
//   ir        in  32  instruction word
//   ins_class out  3  RTYPE/ADDI/LW/SW/BEQ/J/ILLEGAL
//   alu_op    out  3  ADD/SUB/AND/OR/SLT
// ---------------------------------------------------------------------------
module ins_class_decode
    import mc_pkg::*;
(
    input  logic [31:0] ir,
    output ins_class_t  ins_class,
    output logic [2:0]  alu_op
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ir_fields;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    // Register and immediate fields only matter to the datapath.
    assign unused_ir_fields = ^ir[25:6];

    always_comb begin
        ins_class = CLS_ILLEGAL;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin ins_class = CLS_RTYPE; alu_op = ALU_ADD; end
                    FN_SUB: begin ins_class = CLS_RTYPE; alu_op = ALU_SUB; end
                    FN_AND: begin ins_class = CLS_RTYPE; alu_op = ALU_AND; end
                    FN_OR:  begin ins_class = CLS_RTYPE; alu_op = ALU_OR;  end
                    FN_SLT: begin ins_class = CLS_RTYPE; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI: ins_class = CLS_ADDI;
            OP_LW:   ins_class = CLS_LW;
            OP_SW:   ins_class = CLS_SW;
            OP_BEQ:  begin ins_class = CLS_BEQ; alu_op = ALU_SUB; end
            OP_J:    ins_class = CLS_J;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a HALT sink.
// Handles memory request/ready handshakes with a timeout, flags illegal
// instructions, and keeps retired-instruction and cycle counters.
//   clk, clr_n       clock (rising) and async active-low reset
//   ir               latched instruction register
//   alu_zero         ALU zero flag (used in EXEC for beq)
//   mem_ready        memory completes the current request this cycle
//   mem_req/mem_we   memory request and store qualifier
//   ir_we, pc_we, pc_src, alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg
//                    datapath strobes (combinational from state/ir/inputs)
//   illegal, bus_err one-cycle event pulses
//   halted, state    status / debug
//   retired, cycles  CNT_W-bit wrapping counters
// ---------------------------------------------------------------------------
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int MEM_TIMEOUT     = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [31:0]      ir,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             bus_err,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    state_t           state_q;
    state_t           state_d;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;
    logic             waiting;
    logic             retire;
    ins_class_t       ins_class;
    logic [2:0]       dec_alu_op;

    ins_class_decode u_dec (
        .ir        (ir),
        .ins_class (ins_class),
        .alu_op    (dec_alu_op)
    );

    assign state   = state_q;
    assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
    // Last permitted wait cycle; mem_ready in this same cycle still completes.
    assign tmo_hit = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        halted     = 1'b0;

        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    mem_req = 1'b1;
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end else if (tmo_hit) begin
                    bus_err = 1'b1;
                    state_d = HALT;
                end else begin
                    mem_req = 1'b1;
                end
            end
            DECODE: begin
                case (ins_class)
                    CLS_J: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_JUMP;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    CLS_ILLEGAL: begin
                        illegal = 1'b1;
                        state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                alu_op = dec_alu_op;
                case (ins_class)
                    CLS_RTYPE: state_d = WB;
                    CLS_ADDI: begin alu_src_b = 1'b1; state_d = WB; end
                    CLS_LW, CLS_SW: begin alu_src_b = 1'b1; state_d = MEM; end
                    CLS_BEQ: begin
                        pc_src  = PC_BRANCH;
                        pc_we   = alu_zero;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    mem_req = 1'b1;
                    mem_we  = (ins_class == CLS_SW);
                    if (ins_class == CLS_SW) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (tmo_hit) begin
                    bus_err = 1'b1;
                    state_d = HALT;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (ins_class == CLS_SW);
                end
            end
            WB: begin
                reg_we     = 1'b1;
                reg_dst    = (ins_class == CLS_RTYPE);
                mem_to_reg = (ins_class == CLS_LW);
                retire     = 1'b1;
                state_d    = FETCH;
            end
            HALT:    halted = 1'b1;
            default: state_d = FETCH;
        endcase

        // Strobes drop the instant reset asserts so no pending write lands.
        if (!clr_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_src     = PC_PLUS4;
            alu_src_b  = 1'b0;
            alu_op     = ALU_ADD;
            reg_we     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
            bus_err    = 1'b0;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= FETCH;
            tmo_q   <= '0;
            retired <= '0;
            cycles  <= '0;
        end else begin
            state_q <= state_d;
            cycles  <= cycles + CNT_W'(1);
            if (retire) retired <= retired + CNT_W'(1);
            if (state_d != state_q) tmo_q <= '0;
            else if (waiting)       tmo_q <= tmo_q + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. u0: CNT_W=4, MEM_TIMEOUT=4,
// refetch on illegal. u1: defaults with HALT_ON_ILLEGAL=1. Both share the
// stimulus; each scenario task checks its own expected values inline.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic       mem_req, mem_we, ir_we, pc_we, alu_src_b, reg_we, reg_dst, mem_to_reg;
    logic       illegal, bus_err, halted;
    logic [1:0] pc_src;
    logic [2:0] alu_op, state;
    logic [3:0] retired, cycles;

    logic        mem_req_h, mem_we_h, ir_we_h, pc_we_h, alu_src_b_h, reg_we_h, reg_dst_h, mem_to_reg_h;
    logic        illegal_h, bus_err_h, halted_h;
    logic [1:0]  pc_src_h;
    logic [2:0]  alu_op_h, state_h;
    logic [31:0] retired_h, cycles_h;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(4), .MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1'b0)) u0 (
        .clk(clk), .clr_n(clr_n), .ir(ir), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err), .halted(halted),
        .state(state), .retired(retired), .cycles(cycles)
    );

    multicycle_control #(.CNT_W(32), .MEM_TIMEOUT(16), .HALT_ON_ILLEGAL(1'b1)) u1 (
        .clk(clk), .clr_n(clr_n), .ir(ir), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req_h), .mem_we(mem_we_h), .ir_we(ir_we_h), .pc_we(pc_we_h), .pc_src(pc_src_h),
        .alu_src_b(alu_src_b_h), .alu_op(alu_op_h), .reg_we(reg_we_h), .reg_dst(reg_dst_h),
        .mem_to_reg(mem_to_reg_h), .illegal(illegal_h), .bus_err(bus_err_h), .halted(halted_h),
        .state(state_h), .retired(retired_h), .cycles(cycles_h)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; sample lands 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reset pulse; returns in the first FETCH cycle after release.
    task automatic do_reset();
        clr_n = 1'b0;
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        ir = 32'h00221820; mem_ready = 1'b1; alu_zero = 1'b0; clr_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
        checks++; if (ir_we !== 1'b0 || pc_we !== 1'b0) begin failures++; $display("FAIL rst_strobes: got ir_we=%0b pc_we=%0b want 0", ir_we, pc_we); end
        checks++; if (retired !== 4'd0 || cycles !== 4'd0) begin failures++; $display("FAIL rst_counters: got %0d/%0d want 0/0", retired, cycles); end
        checks++; if (mem_req_h !== 1'b0 || halted_h !== 1'b0) begin failures++; $display("FAIL rst_u1: got mem_req=%0b halted=%0b want 0", mem_req_h, halted_h); end
        clr_n = 1'b1; #1;
        checks++; if (mem_req !== 1'b1 || ir_we !== 1'b1) begin failures++; $display("FAIL rst_release_fetch: got mem_req=%0b ir_we=%0b want 1", mem_req, ir_we); end
    endtask

    task automatic test_add();
        ir = 32'h00221820; mem_ready = 1'b1; alu_zero = 1'b0;
        do_reset();
        checks++; if (state !== 3'd0 || pc_we !== 1'b1 || pc_src !== 2'd0) begin failures++; $display("FAIL add_fetch: got st=%0d pc_we=%0b pc_src=%0d want 0/1/0", state, pc_we, pc_src); end
        step();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL add_decode: got %0d want 1", state); end
        step();
        checks++; if (state !== 3'd2 || alu_op !== 3'd0 || alu_src_b !== 1'b0) begin failures++; $display("FAIL add_exec: got st=%0d op=%0d srcb=%0b want 2/0/0", state, alu_op, alu_src_b); end
        step();
        checks++; if (state !== 3'd4 || reg_we !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin failures++; $display("FAIL add_wb: got st=%0d we=%0b dst=%0b m2r=%0b want 4/1/1/0", state, reg_we, reg_dst, mem_to_reg); end
        checks++; if (retired !== 4'd0) begin failures++; $display("FAIL add_retired_wb: got %0d want 0", retired); end
        step();
        checks++; if (state !== 3'd0 || retired !== 4'd1 || cycles !== 4'd4) begin failures++; $display("FAIL add_done: got st=%0d ret=%0d cyc=%0d want 0/1/4", state, retired, cycles); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fn  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [2:0] exp [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        mem_ready = 1'b1; ir = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn[0]};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ir = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn[i]};
            step(); step();
            checks++; if (alu_op !== exp[i]) begin failures++; $display("FAIL b2b_alu_op[%0d]: got %0d want %0d", i, alu_op, exp[i]); end
            step(); step();
            checks++; if (retired !== 4'(i + 1)) begin failures++; $display("FAIL b2b_retired[%0d]: got %0d want %0d", i, retired, i + 1); end
        end
    endtask

    task automatic test_lw();
        ir = 32'h8C220004; mem_ready = 1'b1;
        do_reset();
        step(); step();
        checks++; if (state !== 3'd2 || alu_src_b !== 1'b1 || alu_op !== 3'd0) begin failures++; $display("FAIL lw_exec: got st=%0d srcb=%0b op=%0d want 2/1/0", state, alu_src_b, alu_op); end
        mem_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            step();
            checks++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL lw_mem_wait[%0d]: got st=%0d req=%0b we=%0b want 3/1/0", w, state, mem_req, mem_we); end
        end
        step();
        mem_ready = 1'b1; #1;
        checks++; if (mem_req !== 1'b1 || bus_err !== 1'b0) begin failures++; $display("FAIL lw_ready_at_limit: got req=%0b berr=%0b want 1/0", mem_req, bus_err); end
        step();
        checks++; if (state !== 3'd4 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0 || reg_we !== 1'b1) begin failures++; $display("FAIL lw_wb: got st=%0d m2r=%0b dst=%0b we=%0b want 4/1/0/1", state, mem_to_reg, reg_dst, reg_we); end
        step();
        checks++; if (state !== 3'd0 || retired !== 4'd1 || cycles !== 4'd8) begin failures++; $display("FAIL lw_done: got st=%0d ret=%0d cyc=%0d want 0/1/8", state, retired, cycles); end
    endtask

    task automatic test_sw_addi();
        ir = 32'hAC220004; mem_ready = 1'b1;
        do_reset();
        step(); step(); step();
        checks++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL sw_mem: got st=%0d req=%0b we=%0b want 3/1/1", state, mem_req, mem_we); end
        step();
        checks++; if (state !== 3'd0 || retired !== 4'd1 || cycles !== 4'd4) begin failures++; $display("FAIL sw_done: got st=%0d ret=%0d cyc=%0d want 0/1/4", state, retired, cycles); end
        ir = 32'h20220005;
        step(); step();
        checks++; if (alu_src_b !== 1'b1 || alu_op !== 3'd0) begin failures++; $display("FAIL addi_exec: got srcb=%0b op=%0d want 1/0", alu_src_b, alu_op); end
        step();
        checks++; if (state !== 3'd4 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0 || reg_we !== 1'b1) begin failures++; $display("FAIL addi_wb: got st=%0d dst=%0b m2r=%0b we=%0b want 4/0/0/1", state, reg_dst, mem_to_reg, reg_we); end
        step();
        checks++; if (retired !== 4'd2) begin failures++; $display("FAIL addi_retired: got %0d want 2", retired); end
    endtask

    task automatic test_beq();
        ir = 32'h10220003; mem_ready = 1'b1; alu_zero = 1'b1;
        do_reset();
        step(); step();
        checks++; if (state !== 3'd2 || pc_we !== 1'b1 || pc_src !== 2'd1 || alu_op !== 3'd1) begin failures++; $display("FAIL beq_taken: got st=%0d pc_we=%0b src=%0d op=%0d want 2/1/1/1", state, pc_we, pc_src, alu_op); end
        step();
        checks++; if (state !== 3'd0 || retired !== 4'd1) begin failures++; $display("FAIL beq_taken_retire: got st=%0d ret=%0d want 0/1", state, retired); end
        alu_zero = 1'b0;
        step(); step();
        checks++; if (pc_we !== 1'b0 || pc_src !== 2'd1) begin failures++; $display("FAIL beq_not_taken: got pc_we=%0b src=%0d want 0/1", pc_we, pc_src); end
        step();
        checks++; if (state !== 3'd0 || retired !== 4'd2) begin failures++; $display("FAIL beq_nt_retire: got st=%0d ret=%0d want 0/2", state, retired); end
    endtask

    task automatic test_jump_wrap();
        ir = 32'h08000010; mem_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) begin
                checks++; if (state !== 3'd1 || pc_we !== 1'b1 || pc_src !== 2'd2) begin failures++; $display("FAIL j_decode: got st=%0d pc_we=%0b src=%0d want 1/1/2", state, pc_we, pc_src); end
            end
            step();
            if (k == 8) begin
                checks++; if (retired !== 4'd8 || cycles !== 4'd0) begin failures++; $display("FAIL j_cycles_wrap: got ret=%0d cyc=%0d want 8/0", retired, cycles); end
            end
            if (k == 15) begin
                checks++; if (retired !== 4'd15 || cycles !== 4'd14) begin failures++; $display("FAIL j_ret15: got ret=%0d cyc=%0d want 15/14", retired, cycles); end
            end
            if (k == 16) begin
                checks++; if (retired !== 4'd0 || cycles !== 4'd0 || state !== 3'd0) begin failures++; $display("FAIL j_ret_wrap: got ret=%0d cyc=%0d st=%0d want 0/0/0", retired, cycles, state); end
            end
        end
    endtask

    task automatic test_illegal();
        ir = 32'hFC000000; mem_ready = 1'b1;
        do_reset();
        step();
        checks++; if (illegal !== 1'b1 || illegal_h !== 1'b1 || pc_we !== 1'b0) begin failures++; $display("FAIL ill_pulse: got u0=%0b u1=%0b pc_we=%0b want 1/1/0", illegal, illegal_h, pc_we); end
        step();
        checks++; if (state !== 3'd0 || illegal !== 1'b0 || retired !== 4'd0) begin failures++; $display("FAIL ill_refetch: got st=%0d ill=%0b ret=%0d want 0/0/0", state, illegal, retired); end
        checks++; if (state_h !== 3'd5 || halted_h !== 1'b1) begin failures++; $display("FAIL ill_halt: got st=%0d halted=%0b want 5/1", state_h, halted_h); end
        step(); step();
        checks++; if (state_h !== 3'd5 || halted_h !== 1'b1 || mem_req_h !== 1'b0 || retired_h !== 32'd0) begin failures++; $display("FAIL ill_halt_stays: got st=%0d h=%0b req=%0b ret=%0d want 5/1/0/0", state_h, halted_h, mem_req_h, retired_h); end
        ir = 32'h00221821;
        do_reset();
        step();
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_funct: got %0b want 1", illegal); end
        step();
        checks++; if (state !== 3'd0 || retired !== 4'd0) begin failures++; $display("FAIL ill_funct_next: got st=%0d ret=%0d want 0/0", state, retired); end
    endtask

    task automatic test_timeout();
        ir = 32'h00221820; mem_ready = 1'b1;
        do_reset();
        step(); step(); step(); step();
        mem_ready = 1'b0; #1;
        checks++; if (mem_req !== 1'b1 || bus_err !== 1'b0) begin failures++; $display("FAIL tmo_wait1: got req=%0b berr=%0b want 1/0", mem_req, bus_err); end
        step(); step();
        checks++; if (bus_err !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL tmo_wait3: got berr=%0b st=%0d want 0/0", bus_err, state); end
        step();
        checks++; if (bus_err !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL tmo_buserr: got berr=%0b req=%0b want 1/0", bus_err, mem_req); end
        step();
        checks++; if (state !== 3'd5 || halted !== 1'b1 || mem_req !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL tmo_halt: got st=%0d h=%0b req=%0b berr=%0b want 5/1/0/0", state, halted, mem_req, bus_err); end
        checks++; if (retired !== 4'd1 || cycles !== 4'd8) begin failures++; $display("FAIL tmo_counters: got ret=%0d cyc=%0d want 1/8", retired, cycles); end
        checks++; if (state_h !== 3'd0 || bus_err_h !== 1'b0 || mem_req_h !== 1'b1) begin failures++; $display("FAIL tmo_u1_waiting: got st=%0d berr=%0b req=%0b want 0/0/1", state_h, bus_err_h, mem_req_h); end
        step();
        checks++; if (state !== 3'd5 || cycles !== 4'd9) begin failures++; $display("FAIL tmo_halt_cycles: got st=%0d cyc=%0d want 5/9", state, cycles); end
        clr_n = 1'b0; #2;
        checks++; if (state !== 3'd0 || retired !== 4'd0 || cycles !== 4'd0 || halted !== 1'b0) begin failures++; $display("FAIL tmo_reset: got st=%0d ret=%0d cyc=%0d h=%0b want 0/0/0/0", state, retired, cycles, halted); end
        @(negedge clk); #1;
        clr_n = 1'b1; #1;
        checks++; if (state !== 3'd0 || mem_req !== 1'b1) begin failures++; $display("FAIL tmo_refetch: got st=%0d req=%0b want 0/1", state, mem_req); end
    endtask

    task automatic test_reset_mid();
        ir = 32'hAC220004; mem_ready = 1'b1;
        do_reset();
        step(); step(); step();
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_mem_we: got %0b want 1", mem_we); end
        clr_n = 1'b0; #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL mid_abort: got req=%0b we=%0b st=%0d want 0/0/0", mem_req, mem_we, state); end
        @(negedge clk); #1;
        clr_n = 1'b1; #1;
        checks++; if (retired !== 4'd0 || ir_we !== 1'b1) begin failures++; $display("FAIL mid_after: got ret=%0d ir_we=%0b want 0/1", retired, ir_we); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_lw();
        test_sw_addi();
        test_beq();
        test_jump_wrap();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
